pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage directly downstream of the branch-decision comparator. It consumes the comparator's taken flag (branchN) and the jump redirect from execute, and owns the PC register. It issues one instruction-memory request at a time over a valid/ready handshake. Each fetched instruction, with its PC, goes to decode over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  in  1  system clock, rising edge
rstN  in  1  asynchronous active-low reset
start  in  1  level; 1 = fetching enabled, 0 = stop after current instruction handshake
branchN  in  1  branch taken, from branch comparator, single-cycle pulse
branchTarget  in  DATA_WIDTH  branch target address
jump  in  1  JAL/JALR redirect, single-cycle pulse
jumpTarget  in  DATA_WIDTH  jump target address
imemReqValid  out  1  fetch request valid
imemAddr  out  DATA_WIDTH  fetch address
imemReqReady  in  1  memory accepts request
imemRspValid  in  1  instruction data valid
imemRspData  in  DATA_WIDTH  instruction word
instrValid  out  1  instruction to decode valid
instr  out  DATA_WIDTH  instruction word
instrPc  out  DATA_WIDTH  PC of instr
instrReady  in  1  decode accepts instruction

Behaviour:
- Reset (async, rstN=0): state=IDLE, pc=RESET_PC, stale=0, imemReqValid=0, imemAddr=RESET_PC, instrValid=0, instr=0, instrPc=0.
- All outputs are registered. imemAddr always equals pc.
- States:
  - IDLE: when start=1, go to REQ.
  - REQ: imemReqValid=1. Handshake (valid&ready): reqPc<=pc, pc<=pc+4, go to WAIT.
  - WAIT: waits for imemRspValid. Non-stale response: instr<=imemRspData, instrPc<=reqPc, instrValid<=1, go to HOLD. Stale response: discard it, clear stale, go to REQ (IDLE if start=0).
  - HOLD: instrValid=1. When instrReady=1: instrValid<=0, go to REQ (IDLE if start=0).
- Single outstanding request. Any imemRspValid outside WAIT is ignored.
- Redirect = jump | branchN. Target = jumpTarget if jump=1, else branchTarget (jump has priority). Target bits[1:0] are forced to 0.
- Redirect sets pc<=target in every state; this overrides the pc+4 update in the same cycle.
  - IDLE: only pc changes.
  - REQ without handshake: the request is re-presented next cycle at the new address.
  - REQ with handshake in the same cycle: go to WAIT with stale=1.
  - WAIT: stale<=1. If the response arrives in the same cycle, discard it and go to REQ.
  - HOLD: instrValid<=0 (instruction squashed even if instrReady=1 that cycle), go to REQ.
- Latency: a REQ handshake in cycle t with response in cycle t+k gives instrValid=1 in cycle t+k+1. The minimum redirect-to-request latency is 1 cycle.
- pc+4 wraps modulo 2^DATA_WIDTH (0xFFFF_FFFC -> 0x0000_0000).
- start=0 never aborts an in-flight request: the unit completes WAIT/HOLD first, then goes to IDLE.
- Reset mid-operation: immediate return to reset values. A late memory response is ignored because the unit is in IDLE.

Decomposition:
- Shared package rv_fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}
  - INSTR_BYTES = 4
  - INSTR_NOP = 32'h0000_0013
- One combinational sub-module, pc_next_sel: selects the next PC from pc+4, branchTarget and jumpTarget with the priority and alignment above.
- FSM, stale flag and output registers stay in pc_fetch_unit.

Test Plan:
1. Reset release, start=1, memory ready with 1-cycle response, decode always ready -> imemAddr sequence 0x0, 0x4, 0x8. Each instrPc matches its data; instrValid is a 1-cycle pulse per instruction.
2. branchN=1, branchTarget=0x103 while in REQ without handshake -> next request issues at imemAddr=0x100.
3. jump=1, jumpTarget=0x200 in WAIT, response 0xDEADBEEF arrives 2 cycles later -> no instrValid for 0xDEADBEEF; next request at 0x200.
4. branchN=1 (target 0x40) and jump=1 (target 0x80) in the same cycle -> next request at 0x80.
5. Decode holds instrReady=0 for 5 cycles -> instr/instrPc stable, no new request. A redirect to 0x300 during HOLD -> instrValid drops, next request at 0x300.
6. pc=0xFFFF_FFFC fetched -> next request at 0x0000_0000. Assert rstN=0 while in WAIT -> all outputs return to reset values immediately; a late imemRspValid is ignored.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump beats branch, and any redirect beats sequential advance.
module pc_next_sel
    import rv_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  advance,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jump_target,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] pc_next
);

    assign redirect = jump | branch_taken;

    // Targets are forced to word alignment; the increment wraps naturally.
    always_comb begin
        pc_next = pc;
        if (jump) begin
            pc_next = {jump_target[DATA_WIDTH-1:2], 2'b00};
        end else if (branch_taken) begin
            pc_next = {branch_target[DATA_WIDTH-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc + DATA_WIDTH'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch, feeding decode over valid/ready.
// States: IDLE = not fetching | REQ = request presented | WAIT = awaiting response | HOLD = instruction offered to decode
module pc_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic                  branchN,
    input  logic [DATA_WIDTH-1:0] branchTarget,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jumpTarget,
    output logic                  imemReqValid,
    output logic [DATA_WIDTH-1:0] imemAddr,
    input  logic                  imemReqReady,
    input  logic                  imemRspValid,
    input  logic [DATA_WIDTH-1:0] imemRspData,
    output logic                  instrValid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instrPc,
    input  logic                  instrReady
);

    fetch_state_t          state, state_next;
    logic [DATA_WIDTH-1:0] pc, pc_next, req_pc;
    logic                  stale, stale_next;
    logic                  redirect, req_fire, capture;

    assign req_fire = (state == REQ) && imemReqReady;
    assign imemAddr = pc;

    pc_next_sel #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pc_next_sel (
        .pc           (pc),
        .advance      (req_fire),
        .branch_taken (branchN),
        .branch_target(branchTarget),
        .jump         (jump),
        .jump_target  (jumpTarget),
        .redirect     (redirect),
        .pc_next      (pc_next)
    );

    always_comb begin
        state_next = state;
        stale_next = stale;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = REQ;
            end
            REQ: begin
                if (imemReqReady) begin
                    state_next = WAIT;
                    stale_next = redirect;
                end
            end
            WAIT: begin
                if (imemRspValid) begin
                    if (redirect) begin
                        stale_next = 1'b0;
                        state_next = REQ;
                    end else if (stale) begin
                        stale_next = 1'b0;
                        state_next = start ? REQ : IDLE;
                    end else begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    stale_next = 1'b1;
                end
            end
            HOLD: begin
                // A redirect squashes the held instruction even if decode accepts it.
                if (redirect) begin
                    state_next = REQ;
                end else if (instrReady) begin
                    state_next = start ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            req_pc       <= RESET_PC;
            stale        <= 1'b0;
            imemReqValid <= 1'b0;
            instrValid   <= 1'b0;
            instr        <= '0;
            instrPc      <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            stale        <= stale_next;
            imemReqValid <= (state_next == REQ);
            instrValid   <= (state_next == HOLD);
            if (req_fire) req_pc <= pc;
            if (capture) begin
                instr   <= imemRspData;
                instrPc <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory model with expected-request queue and decode-side scoreboard.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] addr;
        bit          deliver;
    } req_exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } out_exp_t;

    typedef struct {
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic [31:0] exp_addr;
    } redir_vec_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        branchN = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        jump = 1'b0;
    logic [31:0] jumpTarget = '0;
    logic        imemReqReady = 1'b0;
    logic        imemRspValid = 1'b0;
    logic [31:0] imemRspData = '0;
    logic        instrReady = 1'b1;
    logic        imemReqValid;
    logic [31:0] imemAddr;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;

    req_exp_t    exp_q[$];
    out_exp_t    out_q[$];
    int          total = 0;
    int          bad = 0;
    int          valid_cycles = 0;
    int          mem_lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] rsp_addr = '0;

    pc_fetch_unit #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .start       (start),
        .branchN     (branchN),
        .branchTarget(branchTarget),
        .jump        (jump),
        .jumpTarget  (jumpTarget),
        .imemReqValid(imemReqValid),
        .imemAddr    (imemAddr),
        .imemReqReady(imemReqReady),
        .imemRspValid(imemRspValid),
        .imemRspData (imemRspData),
        .instrValid  (instrValid),
        .instr       (instr),
        .instrPc     (instrPc),
        .instrReady  (instrReady)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || out_q.size() != 0) && n < 60) begin
            step();
            n++;
        end
        check(nm, 32'(n < 60), 32'd1);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!imemReqValid && n < 20) begin
            step();
            n++;
        end
        check(nm, 32'(imemReqValid), 32'd1);
    endtask

    // Memory: accepts only requests the bench expects; responds mem_lat cycles later.
    initial begin
        req_exp_t e;
        forever begin
            @(negedge clk);
            imemRspValid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imemRspValid = 1'b1;
                    imemRspData  = mem_word(rsp_addr);
                    pend         = 1'b0;
                end
            end
            imemReqReady = (exp_q.size() != 0);
            if (rstN && imemReqValid && imemReqReady) begin
                e = exp_q.pop_front();
                check("req_addr", imemAddr, e.addr);
                if (e.deliver) out_q.push_back('{e.addr, mem_word(e.addr)});
                pend     = 1'b1;
                cnt      = mem_lat;
                rsp_addr = imemAddr;
            end
        end
    end

    // Decode side scoreboard.
    initial begin
        out_exp_t o;
        forever begin
            @(negedge clk);
            if (rstN && instrValid) valid_cycles++;
            if (rstN && instrValid && instrReady) begin
                total++;
                if (out_q.size() == 0) begin
                    bad++;
                    $display("FAIL instr_unexpected: got pc %h data %h, want no instruction", instrPc, instr);
                end else begin
                    o = out_q.pop_front();
                    if (instrPc !== o.pc || instr !== o.data) begin
                        bad++;
                        $display("FAIL instr_out: got pc %h data %h want pc %h data %h",
                                 instrPc, instr, o.pc, o.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t vecs[6];
        int         vc0;
        int         n;

        vecs[0] = '{1'b1, 32'h0000_0103, 1'b0, 32'h0000_0000, 32'h0000_0100};
        vecs[1] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080, 32'h0000_0080};
        vecs[2] = '{1'b0, 32'h0000_0555, 1'b1, 32'h0000_01FF, 32'h0000_01FC};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0200};
        vecs[4] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC};
        vecs[5] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};

        step();
        step();
        check("rst_req_valid", 32'(imemReqValid), 32'd0);
        check("rst_addr", imemAddr, 32'h0);
        check("rst_instr_valid", 32'(instrValid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instrPc, 32'h0);
        rstN = 1'b1;
        step();

        // Sequential fetch 0x0, 0x4, 0x8 with 1-cycle memory and always-ready decode.
        exp_q.push_back('{32'h0, 1'b1});
        exp_q.push_back('{32'h4, 1'b1});
        exp_q.push_back('{32'h8, 1'b1});
        vc0   = valid_cycles;
        start = 1'b1;
        step();
        check("t1_req_latency", 32'(imemReqValid), 32'd1);
        step();
        step();
        check("t1_rsp_latency", 32'(instrValid), 32'd1);
        check("t1_first_pc", instrPc, 32'h0);
        wait_idle("t1_timeout");
        check("t1_valid_pulses", 32'(valid_cycles - vc0), 32'd3);

        // Redirects while a request is presented but not accepted.
        foreach (vecs[i]) begin
            wait_req($sformatf("vec%0d_in_req", i));
            branchN      = vecs[i].br;
            branchTarget = vecs[i].bt;
            jump         = vecs[i].jp;
            jumpTarget   = vecs[i].jt;
            step();
            branchN = 1'b0;
            jump    = 1'b0;
            check($sformatf("vec%0d_addr", i), imemAddr, vecs[i].exp_addr);
            check($sformatf("vec%0d_req_valid", i), 32'(imemReqValid), 32'd1);
            exp_q.push_back('{vecs[i].exp_addr, 1'b1});
            wait_idle($sformatf("vec%0d_timeout", i));
        end

        // Redirect in the same cycle as the request handshake: response must be dropped.
        wait_req("hs_in_req");
        exp_q.push_back('{32'h4, 1'b0});
        branchN      = 1'b1;
        branchTarget = 32'h0000_0403;
        step();
        branchN = 1'b0;
        check("hs_in_wait", 32'(imemReqValid), 32'd0);
        check("hs_pc", imemAddr, 32'h0000_0400);
        exp_q.push_back('{32'h400, 1'b1});
        wait_idle("hs_timeout");

        // Jump during WAIT, response two cycles later is discarded.
        wait_req("t3_in_req");
        mem_lat = 3;
        exp_q.push_back('{32'h404, 1'b0});
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("t3_in_wait", 32'(imemReqValid), 32'd0);
        jump       = 1'b1;
        jumpTarget = 32'h0000_0200;
        step();
        jump    = 1'b0;
        mem_lat = 1;
        check("t3_pc", imemAddr, 32'h0000_0200);
        exp_q.push_back('{32'h200, 1'b1});
        wait_idle("t3_timeout");

        // Decode stalls in HOLD, then a redirect squashes the held instruction.
        wait_req("t5_in_req");
        instrReady = 1'b0;
        exp_q.push_back('{32'h204, 1'b1});
        n = 0;
        while (!instrValid && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("t5_hold_valid", 32'(instrValid), 32'd1);
            check("t5_hold_pc", instrPc, 32'h204);
            check("t5_hold_instr", instr, mem_word(32'h204));
            check("t5_no_req", 32'(imemReqValid), 32'd0);
            step();
        end
        jump       = 1'b1;
        jumpTarget = 32'h0000_0301;
        step();
        jump = 1'b0;
        check("t5_squash", 32'(instrValid), 32'd0);
        check("t5_pc", imemAddr, 32'h0000_0300);
        out_q.delete();
        instrReady = 1'b1;
        exp_q.push_back('{32'h300, 1'b1});
        wait_idle("t5_timeout");

        // Reset while waiting; the late response must be ignored.
        wait_req("t6_in_req");
        mem_lat = 3;
        exp_q.push_back('{32'h304, 1'b0});
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("t6_in_wait", 32'(imemReqValid), 32'd0);
        start = 1'b0;
        rstN  = 1'b0;
        #1;
        check("t6_rst_req_valid", 32'(imemReqValid), 32'd0);
        check("t6_rst_addr", imemAddr, 32'h0);
        check("t6_rst_instr_valid", 32'(instrValid), 32'd0);
        check("t6_rst_instr", instr, 32'h0);
        check("t6_rst_instr_pc", instrPc, 32'h0);
        mem_lat = 1;
        step();
        rstN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_late_instr_valid", 32'(instrValid), 32'd0);
            check("t6_idle_req_valid", 32'(imemReqValid), 32'd0);
        end
        start = 1'b1;
        exp_q.push_back('{32'h0, 1'b1});
        wait_idle("t6_timeout");

        check("end_req_queue", 32'(exp_q.size()), 32'd0);
        check("end_out_queue", 32'(out_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
